// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a small first-word-fall-through byte FIFO.
// The receiver runs continuously; the FIFO head is popped with rd_en.
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          serial_In,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shreg, shreg_n;
    logic           s1, s2, s3;
    logic           fall;
    logic           push_req;
    logic           ferr_n;
    logic           push;
    logic           pop;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wp, rp;

    // Preset to idle-high so reset release never looks like a start bit
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= serial_In;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {s2, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so the next start edge is not missed
                if (cnt == CNT_LAST) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    push_req = s2;
                    ferr_n   = ~s2;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // A same-cycle pop frees a slot, so a full FIFO can still accept
    assign pop  = rd_en & ~empty;
    assign push = push_req & (~full | pop);

    always_ff @(posedge sysclk) begin
        if (push) mem[wp] <= shreg;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            frame_err <= ferr_n;
            overrun   <= push_req & ~push;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign rd_data = empty ? 8'h00 : mem[rp];
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: serial frames in, FIFO bytes out.
// Expected bytes are queued when a frame is driven and compared on pop.
module tb_uart_rx_buffer;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    logic [7:0] q[$];

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sysclk(clk),
        .reset(rst_n),
        .serial_In(serial),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .count(count),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 serial = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 serial = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 serial = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 serial = 1'b1;
    endtask

    task automatic read_check(input string name);
        logic [7:0] exp;
        @(negedge clk);
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", name, rd_data);
        end else begin
            exp = q.pop_front();
            if (empty !== 1'b0 || rd_data !== exp) begin
                failures++;
                $display("FAIL %s: got %h empty=%b expected %h",
                         name, rd_data, empty, exp);
            end
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({empty, full, count, rd_data, frame_err, overrun, busy}
            !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: got e=%b f=%b c=%0d d=%h fe=%b ov=%b b=%b",
                     empty, full, count, rd_data, frame_err, overrun, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single_byte();
        int n = 0;
        q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                while (empty && n < 200) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
            end
        join
        checks++;
        if (n < 150 || n > 160) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected ~155", n);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL single_count: got %0d expected 1", count);
        end
        read_check("single_data");
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            failures++;
            $display("FAIL single_pop: got e=%b c=%0d expected e=1 c=0",
                     empty, count);
        end
    endtask

    task automatic test_glitch();
        int busy_cycles = 0;
        int f0 = ferr_seen;
        int o0 = ovr_seen;
        @(posedge clk);
        #1 serial = 1'b0;
        repeat (5) @(posedge clk);
        #1 serial = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles < 1 || busy_cycles > 8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy: got %0d busy cycles expected 1..8",
                     busy_cycles);
        end
        checks++;
        if (count !== 3'd0 || ferr_seen != f0 || ovr_seen != o0) begin
            failures++;
            $display("FAIL glitch_quiet: got c=%0d fe=%0d ov=%0d expected 0",
                     count, ferr_seen - f0, ovr_seen - o0);
        end
    endtask

    task automatic test_frame_error();
        int f0 = ferr_seen;
        send_frame(8'h3C, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (ferr_seen - f0 != 1 || count !== 3'd0) begin
            failures++;
            $display("FAIL frame_err: got %0d pulse cycles c=%0d expected 1 c=0",
                     ferr_seen - f0, count);
        end
        q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        read_check("after_ferr");
    endtask

    task automatic test_overrun();
        int o0;
        for (int i = 1; i <= 4; i++) begin
            q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL fill: got f=%b c=%0d expected f=1 c=4", full, count);
        end
        o0 = ovr_seen;
        send_frame(8'h05, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (ovr_seen - o0 != 1 || count !== 3'd4) begin
            failures++;
            $display("FAIL overrun: got %0d pulse cycles c=%0d expected 1 c=4",
                     ovr_seen - o0, count);
        end
        for (int i = 0; i < 4; i++) read_check("drain_ovr");
        @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL drained: got empty=%b expected 1", empty);
        end
    endtask

    task automatic test_full_pop();
        int o0;
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        @(negedge clk);
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_before: got full=%b expected 1", full);
        end
        o0 = ovr_seen;
        fork
            send_frame(8'h15, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rd_en = 1'b1;
                checks++;
                if (rd_data !== q[0]) begin
                    failures++;
                    $display("FAIL push_pop_head: got %h expected %h",
                             rd_data, q[0]);
                end
                void'(q.pop_front());
                q.push_back(8'h15);
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        checks++;
        if (ovr_seen != o0 || count !== 3'd4) begin
            failures++;
            $display("FAIL push_pop_full: got ov=%0d c=%0d expected 0 c=4",
                     ovr_seen - o0, count);
        end
        for (int i = 0; i < 4; i++) read_check("drain_full_pop");
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL pop_empty: got c=%0d e=%b expected 0 1",
                     count, empty);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'hC3;
        q.push_back(8'h99);
        send_frame(8'h99, 1'b1);
        @(negedge clk);
        checks++;
        if (count !== 3'd1) begin
            failures++;
            $display("FAIL pre_reset: got c=%0d expected 1", count);
        end
        @(posedge clk);
        #1 serial = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (CPB) @(posedge clk);
            #1 serial = b[i];
        end
        repeat (CPB / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        serial = 1'b1;
        q.delete();
        @(negedge clk);
        checks++;
        if ({empty, full, count, rd_data, frame_err, overrun, busy}
            !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got e=%b f=%b c=%0d d=%h fe=%b ov=%b b=%b",
                     empty, full, count, rd_data, frame_err, overrun, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        read_check("after_reset");
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL final_idle: got e=%b b=%b expected 1 0", empty, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Serial receive front end that feeds the tweetboard text path.
- Deserialises the 8N1 UART stream arriving on serial_In and stores received bytes in a small first-word-fall-through FIFO.
- The tweetboard pops bytes with a one-cycle read strobe.
- Runs continuously, independent of the mode select, so bytes arriving while another board is active are buffered, not lost.

Parameters:
- CLKS_PER_BIT, 5208: sysclk cycles per UART bit (50 MHz / 9600 baud); legal values are 4 or more.
- FIFO_DEPTH, 8: byte entries; must be a power of two, 2 or more.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- serial_In  in  1  asynchronous UART line; idles high.
- rd_en  in  1  pop strobe; ignored while empty.
- rd_data  out  8  byte at the FIFO head; valid while empty=0.
- empty  out  1  FIFO holds 0 bytes.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- count  out  log2(FIFO_DEPTH)+1  bytes held (0..FIFO_DEPTH).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because FIFO full.
- busy  out  1  receiver not in IDLE.

Behaviour:
Reset (reset=0, asynchronous):
- FSM goes to IDLE; FIFO pointers and count clear.
- Outputs: empty=1, full=0, count=0, rd_data=0, frame_err=0, overrun=0, busy=0.
- Synchroniser flops preset to 1 so no false start is detected on release.
- Reset mid-frame discards the partial byte. FIFO contents are lost.

Input synchroniser:
- Two flops on serial_In produce rx_s.
- A falling edge is detected against a third, registered copy of rx_s.

Receiver FSM, states IDLE, START, DATA, STOP; bit counter 0..CLKS_PER_BIT-1; bit index 0..7:
- IDLE: a falling edge on rx_s clears the counter and moves to START. busy=1 from the next cycle.
- START: at counter=CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - If 1, it was a glitch: return to IDLE with no output.
  - If 0, clear the counter and go to DATA. Every later sample is taken at mid-bit.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into a shift register, LSB first.
  - After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1 and FIFO not full: push the byte.
  - If 1 and FIFO full: drop the byte and pulse overrun.
  - If 0: drop the byte and pulse frame_err. No push.
  - In every case return to IDLE on the same edge.
  - Returning at mid-stop-bit allows back-to-back frames and tolerates slight baud mismatch.
- A low line held after a framing error does not start a new frame until a fresh falling edge.

Latency:
- The push happens on the edge of the stop-bit sample, about 9.5 bit times plus 3 cycles after the line's falling edge.
- empty deasserts and rd_data is valid on the cycle after that edge.

FIFO:
- Circular buffer with wrap-around pointers.
- rd_data is combinational from the head entry (FWFT).
- rd_en while empty=0: head advances, count decrements, and the next byte appears the following cycle.
- rd_en while empty=1: no effect; count does not underflow.
- Push and pop in the same cycle when not empty: both occur and count is unchanged.
- Push while full with pop in the same cycle: the pop frees a slot, the push is accepted, and there is no overrun.
- Push while empty with rd_en: rd_en is ignored (empty) and the push lands.
- full and empty are derived from count and update on the same edge as count.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) -> empty falls about 155 cycles after the start edge; rd_data=0xA5, count=1; rd_en pulse -> empty=1, count=0.
2. Drive a 5-cycle low glitch on idle serial_In -> no push, no pulses, busy returns to 0 within 8 cycles of the glitch's falling edge.
3. Send 0x3C with the stop bit held low -> frame_err pulses exactly 1 cycle, count stays 0; then send 0x7E normally -> rd_data=0x7E.
4. Send 5 back-to-back bytes 0x01..0x05 with no reads -> after the 4th, full=1, count=4; the 5th raises a one-cycle overrun pulse; reads return 0x01,0x02,0x03,0x04, then empty=1.
5. With full=1, assert rd_en on the exact push cycle of the 5th byte -> no overrun, count stays 4, and the drained order ends with 0x05; also assert rd_en while empty -> count stays 0.
6. Assert reset low midway through DATA of a frame, then release -> all outputs at reset values; the next clean frame 0x55 is received correctly.
